// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the multiply/divide unit and the decoder that drives it.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'b000,
    MULTU = 3'b001,
    DIV   = 3'b010,
    DIVU  = 3'b011,
    MTHI  = 3'b100,
    MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } muldiv_state_t;

  localparam int unsigned ITERATIONS = 32;

  // Magnitude of a 32-bit operand. 33 bits so that -2^31 becomes +2^31.
  function automatic logic [32:0] mag33(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 33'd0 - {1'b1, v};
    end
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of the iterative datapath: shift-add multiply or restoring divide.
// Multiply: acc = {0, partial_hi[32 bits], multiplier bits}, shifted right.
// Divide:   acc = {remainder[33 bits], dividend/quotient bits}, shifted left.
module mips_cpu_muldiv_step
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [64:0] acc_i,
  input  logic [32:0] opnd_i,
  output logic [64:0] acc_o
);

  logic [32:0] sum;
  logic [33:0] shifted;
  logic [33:0] diff;

  // Select shift-add or trial-subtract for this iteration.
  always_comb begin
    sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? opnd_i : '0);
    shifted = {acc_i[64:32], acc_i[31]};
    diff    = shifted - {1'b0, opnd_i};
    if (!is_div) begin
      acc_o = {1'b0, sum, acc_i[31:1]};
    end else if (!diff[33]) begin
      acc_o = {diff[32:0], acc_i[30:0], 1'b1};
    end else begin
      acc_o = {shifted[32:0], acc_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic [64:0]   acc_q, acc_d;
  logic [32:0]   opnd_q, opnd_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  logic          is_signed;
  logic [32:0]   mag_a, mag_b;
  logic [64:0]   acc_step;

  mips_cpu_muldiv_step u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state: IDLE -> CALC (32 iterations) -> FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (op inside {MULT, MULTU, DIV, DIVU})) state_d = CALC;
      CALC:    if (cnt_q == 5'(ITERATIONS - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and HI/LO write.
  // Divide by zero needs no special case: restoring division yields an
  // all-ones quotient and the dividend magnitude as remainder; only the
  // quotient negation is suppressed so LO stays 0xFFFFFFFF.
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_signed = (op == MULT) || (op == DIV);
    mag_a     = mag33(a, is_signed);
    mag_b     = mag33(b, is_signed);
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MULT, MULTU: begin
              is_div_d  = 1'b0;
              opnd_d    = mag_a;
              acc_d     = {33'd0, mag_b[31:0]};
              neg_res_d = is_signed && (a[31] ^ b[31]);
              neg_rem_d = 1'b0;
              cnt_d     = '0;
            end
            DIV, DIVU: begin
              is_div_d  = 1'b1;
              opnd_d    = mag_b;
              acc_d     = {33'd0, mag_a[31:0]};
              neg_res_d = is_signed && (a[31] ^ b[31]) && (b != '0);
              neg_rem_d = is_signed && a[31];
              cnt_d     = '0;
            end
            MTHI:    hi_d = a;
            MTLO:    lo_d = a;
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 5'd1;
      end
      FIX: begin
        done_d = 1'b1;
        if (is_div_q) begin
          lo_d = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
          hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = neg_res_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for the iterative multiply/divide unit.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Pulse start for one edge, then wait (bounded) for done; sampled #1 after edges.
  task automatic run_op(input muldiv_op_t o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bcnt);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin lat = k; break; end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_multu();
    int lat, bcnt;
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d want 33", lat); end
    n_checks++; if (bcnt !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bcnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
    n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFFFFFE); end
    n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want %h", lo, 32'h00000001); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mult();
    int lat, bcnt;
    run_op(MULT, 32'hFFFFFFFD, 32'd7, lat, bcnt);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d want 33", lat); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFFFFFF); end
    n_checks++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFFFFEB); end
  endtask

  task automatic test_div_signed();
    int lat, bcnt;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h want %h", lo, 32'hFFFFFFFD); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h want %h", hi, 32'hFFFFFFFF); end
  endtask

  task automatic test_divu();
    int lat, bcnt;
    run_op(DIVU, 32'd100, 32'd7, lat, bcnt);
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_div_overflow();
    int lat, bcnt;
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo: got %h want %h", lo, 32'h80000000); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL divovf_hi: got %h want %h", hi, 32'h0); end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    run_op(DIVU, 32'd5, 32'd0, lat, bcnt);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu0_latency: got %0d want 33", lat); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_lo: got %h want %h", lo, 32'hFFFFFFFF); end
    n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divu0_hi: got %h want %h", hi, 32'd5); end
    run_op(DIV, 32'hFFFFFFF9, 32'd0, lat, bcnt);
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_lo: got %h want %h", lo, 32'hFFFFFFFF); end
    n_checks++; if (hi !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL div0_hi: got %h want %h", hi, 32'hFFFFFFF9); end
  endtask

  task automatic test_mthi();
    @(negedge clk);
    op = MTHI; a = 32'h1234; b = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi: got %h want %h", hi, 32'h1234); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mthi_lo_kept: got %h want %h", lo, 32'hFFFFFFFF); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", busy); end
    @(negedge clk);
    op = MTLO; a = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo_lo: got %h want %h", lo, 32'h5678); end
  endtask

  task automatic test_mtlo_busy();
    int lat;
    @(negedge clk);
    op = MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = MTLO; a = 32'hDEAD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo_busy_hold: got %h want %h", lo, 32'h5678); end
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat < 0) begin n_fail++; $display("FAIL mtlo_busy_timeout: got no done want done"); end
    n_checks++; if (lo !== 32'd15) begin n_fail++; $display("FAIL mtlo_busy_lo: got %h want %h", lo, 32'd15); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mtlo_busy_hi: got %h want %h", hi, 32'd0); end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = MULTU; a = 32'd2; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL restart_latency: got %0d want 27", lat); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL restart_lo: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL restart_hi: got %h want %h", hi, 32'd2); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_not_queued: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt;
    @(negedge clk);
    op = MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h want %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h want %h", lo, 32'h0); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    @(negedge clk);
    reset = 1'b0;
    run_op(MULTU, 32'd3, 32'd5, lat, bcnt);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d want 33", lat); end
    n_checks++; if (lo !== 32'd15) begin n_fail++; $display("FAIL abort_rerun_lo: got %h want %h", lo, 32'd15); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run_op(MULT, 32'h80000000, 32'h80000000, lat, bcnt);
    n_checks++; if (hi !== 32'h40000000) begin n_fail++; $display("FAIL b2b_mult_hi: got %h want %h", hi, 32'h40000000); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL b2b_mult_lo: got %h want %h", lo, 32'h0); end
    // Next start lands in the done cycle.
    run_op(DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_div_latency: got %0d want 33", lat); end
    n_checks++; if (bcnt !== 33) begin n_fail++; $display("FAIL b2b_div_busy_cycles: got %0d want 33", bcnt); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL b2b_div_lo: got %h want %h", lo, 32'hFFFFFFFD); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL b2b_div_hi: got %h want %h", hi, 32'd1); end
  endtask

  task automatic test_reserved();
    @(negedge clk);
    op = muldiv_op_t'(3'b110); a = 32'hAAAA5555; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reserved_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL reserved_hi: got %h want %h", hi, 32'd1); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL reserved_lo: got %h want %h", lo, 32'hFFFFFFFD); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div_signed();
    test_divu();
    test_div_overflow();
    test_div_zero();
    test_mthi();
    test_mtlo_busy();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_reserved();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
